// File: rtl/zpc_int_pkg.sv
// rtl/zpc_int_pkg.sv - shared constants and types for the interrupt controller (INT_CTRL_LEVEL_EN selects level-mode sources)
package zpc_int_pkg;

    // Byte offsets of the three registers inside the window
    localparam logic [3:0] REG_OFF_MASK  = 4'h0;
    localparam logic [3:0] REG_OFF_PEND  = 4'h4;
    localparam logic [3:0] REG_OFF_CAUSE = 4'h8;

    // Cause code of source 0; kept clear of the syscall cause 8
    localparam int unsigned CAUSE_BASE_DEF = 16;

    // CPU Memwrite type codes
    localparam logic [1:0] MW_NONE = 2'd0;
    localparam logic [1:0] MW_WORD = 2'd1;
    localparam logic [1:0] MW_DMA  = 2'd2;
    localparam logic [1:0] MW_BYTE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Only CPU word and byte stores reach the registers; DMA traffic passes by
    function automatic logic wr_accepted(input logic [1:0] mw);
        logic acc;
        case (mw)
            MW_WORD, MW_BYTE: acc = 1'b1;
            MW_NONE, MW_DMA:  acc = 1'b0;
            default:          acc = 1'b0;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-wins priority encoder, 8 requests to 3-bit index
module int_prio_enc (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       valid
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - memory-mapped 8-source interrupt controller (INT_CTRL_LEVEL_EN selects level-mode sources)
module int_ctrl
    import zpc_int_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
    parameter int unsigned CAUSE_BASE  = CAUSE_BASE_DEF,
    parameter int unsigned HOLDOFF_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  irq,
    input  logic        Memread,
    input  logic [1:0]  Memwrite,
    input  logic [31:0] Addr,
    inout  wire  [31:0] BUS,
    output logic        INTout,
    output logic [31:0] INTnum
);

    // Counter load after an ACK; the HOLD state spends HOLDOFF_CYC cycles counting down to 0
    localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_CYC - 1);

    logic [7:0]  mask_q, mask_d;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  irq_hist_q, irq_hist_d;
    logic [31:0] rdata_q, rdata_d;

    state_e      state_q, state_d;
    logic [2:0]  id_q, id_d;
    logic [31:0] intnum_q, intnum_d;
    logic        intout_q, intout_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        hit;
    logic [3:0]  reg_off;
    logic        wr_en;
    logic        wr_mask, wr_pend, wr_ack;
    logic [7:0]  bus_in;
    logic [7:0]  rise;
    logic [7:0]  ack_clr;
    logic [2:0]  enc_idx;
    logic        enc_valid;
    logic        unused_bits;

    // Address decode: upper 28 bits select the window, Addr[3:2]==3 is a hole
    assign hit     = (Addr[31:4] == BASE_ADDR[31:4]) && (Addr[3:2] != 2'b11);
    assign reg_off = {Addr[3:2], 2'b00};
    assign wr_en   = hit && wr_accepted(Memwrite);
    assign wr_mask = wr_en && (reg_off == REG_OFF_MASK);
    assign wr_pend = wr_en && (reg_off == REG_OFF_PEND);
    assign wr_ack  = wr_en && (reg_off == REG_OFF_CAUSE);
    assign bus_in  = BUS[7:0];
    assign rise    = irq & ~irq_hist_q;

    assign unused_bits = ^{Addr[1:0], BUS[31:8]};

    // Only enabled pending sources compete for service
    int_prio_enc u_prio_enc (
        .req   (pend_q & mask_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Register file next-state: mask, pending bits, irq history and read data
    always_comb begin
        mask_d     = wr_mask ? bus_in : mask_q;
        irq_hist_d = irq;
`ifdef INT_CTRL_LEVEL_EN
        // Pending mirrors the sources; software writes and ACK never touch it
        pend_d     = irq;
`else
        // A new edge always beats a same-cycle clear so no event is lost
        pend_d     = (pend_q & ~(wr_pend ? bus_in : 8'h00) & ~ack_clr) | rise;
`endif
        rdata_d    = rdata_q;
        if (Memread && hit) begin
            case (reg_off)
                REG_OFF_MASK: rdata_d = {24'h0, mask_q};
                REG_OFF_PEND: rdata_d = {24'h0, pend_q};
                default:      rdata_d = intnum_q;
            endcase
        end
    end

`ifdef INT_CTRL_LEVEL_EN
    logic unused_level;
    assign unused_level = ^{rise, wr_pend, ack_clr};
`endif

    // Register file state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= 8'h00;
            pend_q     <= 8'h00;
            irq_hist_q <= 8'h00;
            rdata_q    <= 32'h0;
        end else begin
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            irq_hist_q <= irq_hist_d;
            rdata_q    <= rdata_d;
        end
    end

    // Request FSM next-state: arbitrate in IDLE, hold request until ACK, then back off
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        intnum_d = intnum_q;
        intout_d = intout_q;
        cnt_d    = cnt_q;
        ack_clr  = 8'h00;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    id_d     = enc_idx;
                    intnum_d = 32'(CAUSE_BASE) + {29'h0, enc_idx};
                    intout_d = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (wr_ack) begin
                    ack_clr  = 8'h01 << id_q;
                    cnt_d    = HOLD_LOAD;
                    intout_d = 1'b0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                intout_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // Request FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            id_q     <= 3'd0;
            intnum_q <= 32'h0;
            intout_q <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            intnum_q <= intnum_d;
            intout_q <= intout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign INTout = intout_q;
    assign INTnum = intnum_q;

    // Drive the shared bus only for our own reads, and never while in reset
    assign BUS = (rst_n && Memread && hit) ? rdata_q : 32'bz;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed scoreboard bench for int_ctrl (INT_CTRL_LEVEL_EN selects the level-mode sequence)
module tb_int_ctrl;

    localparam logic [31:0] BASE    = 32'hFFFF_FF00;
    localparam int          CBASE   = 16;
    localparam int          HOLDOFF = 8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq;
    logic        Memread;
    logic [1:0]  Memwrite;
    logic [31:0] Addr;
    logic        INTout;
    logic [31:0] INTnum;
    logic [31:0] bus_drv;
    logic        bus_oe;
    tri1  [31:0] bus;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    assign bus = bus_oe ? bus_drv : 32'bz;

    int_ctrl #(
        .BASE_ADDR   (BASE),
        .CAUSE_BASE  (CBASE),
        .HOLDOFF_CYC (HOLDOFF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq      (irq),
        .Memread  (Memread),
        .Memwrite (Memwrite),
        .Addr     (Addr),
        .BUS      (bus),
        .INTout   (INTout),
        .INTnum   (INTnum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] mw);
        Addr     = a;
        bus_drv  = d;
        bus_oe   = 1'b1;
        Memwrite = mw;
        tick();
        Memwrite = 2'd0;
        bus_oe   = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        Addr    = a;
        Memread = 1'b1;
        tick();
        sb_check(tag, bus);
        Memread = 1'b0;
    endtask

    task automatic ack();
        bus_write(BASE + 32'h8, 32'h0, 2'd1);
    endtask

    task automatic wait_int(output int n);
        n = 0;
        while (INTout !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < HOLDOFF + 4; i++) tick();
    endtask

    int n;

    initial begin
        rst_n    = 1'b0;
        irq      = 8'h00;
        Memread  = 1'b1;
        Memwrite = 2'd0;
        Addr     = BASE;
        bus_drv  = 32'h0;
        bus_oe   = 1'b0;
        tick();
        tick();
        chk("reset_intout", {31'h0, INTout}, 32'h0);
        chk("reset_intnum", INTnum, 32'h0);
        chk("reset_bus_hiz", bus, 32'hFFFF_FFFF);
        Memread = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

`ifndef INT_CTRL_LEVEL_EN
        // Single enabled source, two-cycle latency
        bus_write(BASE, 32'h04, 2'd1);
        irq = 8'h04;
        exp_q.push_back(CBASE + 2);
        tick();
        irq = 8'h00;
        chk("lat_cycle1_intout", {31'h0, INTout}, 32'h0);
        tick();
        chk("lat_cycle2_intout", {31'h0, INTout}, 32'h1);
        sb_check("irq2_intnum", INTnum);
        bus_read("irq2_pend", BASE + 32'h4, 32'h04);
        bus_read("irq2_cause", BASE + 32'h8, CBASE + 2);
        ack();
        drain();
        chk("irq2_after_ack_intout", {31'h0, INTout}, 32'h0);
        bus_read("irq2_pend_cleared", BASE + 32'h4, 32'h00);

        // Two sources together: lowest wins, the other follows after holdoff
        bus_write(BASE, 32'hFF, 2'd1);
        irq = 8'h22;
        exp_q.push_back(CBASE + 1);
        exp_q.push_back(CBASE + 5);
        tick();
        irq = 8'h00;
        tick();
        chk("prio_intout", {31'h0, INTout}, 32'h1);
        sb_check("prio_intnum_first", INTnum);
        ack();
        wait_int(n);
        chk("holdoff_low_cycles", n, HOLDOFF + 1);
        sb_check("prio_intnum_second", INTnum);
        ack();
        drain();
        chk("prio_drained_intout", {31'h0, INTout}, 32'h0);

        // Masked source stays pending until enabled
        bus_write(BASE, 32'h00, 2'd1);
        irq = 8'h08;
        tick();
        irq = 8'h00;
        tick();
        tick();
        chk("masked_intout", {31'h0, INTout}, 32'h0);
        bus_read("masked_pend", BASE + 32'h4, 32'h08);
        exp_q.push_back(CBASE + 3);
        bus_write(BASE, 32'h08, 2'd1);
        chk("unmask_cycle1_intout", {31'h0, INTout}, 32'h0);
        tick();
        chk("unmask_cycle2_intout", {31'h0, INTout}, 32'h1);
        sb_check("unmask_intnum", INTnum);
        ack();
        drain();

        // Set beats same-cycle W1C; DMA writes ignored; decode details
        bus_write(BASE, 32'h00, 2'd1);
        irq = 8'h01;
        bus_write(BASE + 32'h4, 32'h01, 2'd1);
        irq = 8'h00;
        bus_read("set_wins_pend", BASE + 32'h4, 32'h01);
        bus_write(BASE + 32'h4, 32'h01, 2'd1);
        bus_read("w1c_pend", BASE + 32'h4, 32'h00);
        bus_write(BASE, 32'hFF, 2'd2);
        bus_read("dma_write_ignored", BASE, 32'h00);
        bus_write(BASE + 32'h3, 32'hFFFF_FF5A, 2'd3);
        bus_read("byte_write_mask", BASE + 32'h1, 32'h5A);
        bus_read("hole_not_driven", BASE + 32'hC, 32'hFFFF_FFFF);
        bus_read("miss_not_driven", BASE + 32'h10, 32'hFFFF_FFFF);
        bus_write(BASE, 32'h00, 2'd1);
        chk("decode_intout", {31'h0, INTout}, 32'h0);

        // Asynchronous reset while requesting
        bus_write(BASE, 32'h04, 2'd1);
        irq = 8'h04;
        tick();
        irq = 8'h00;
        tick();
        chk("pre_reset_intout", {31'h0, INTout}, 32'h1);
        Addr    = BASE;
        Memread = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_intout", {31'h0, INTout}, 32'h0);
        chk("async_reset_bus_hiz", bus, 32'hFFFF_FFFF);
        Memread = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus_read("post_reset_mask", BASE, 32'h00);
        bus_read("post_reset_pend", BASE + 32'h4, 32'h00);
        tick();
        chk("post_reset_intout", {31'h0, INTout}, 32'h0);
`else
        // Level mode: pending follows the source, request returns after holdoff
        bus_write(BASE, 32'h10, 2'd1);
        irq = 8'h10;
        exp_q.push_back(CBASE + 4);
        exp_q.push_back(CBASE + 4);
        tick();
        chk("lvl_cycle1_intout", {31'h0, INTout}, 32'h0);
        tick();
        chk("lvl_cycle2_intout", {31'h0, INTout}, 32'h1);
        sb_check("lvl_intnum_first", INTnum);
        bus_read("lvl_pend_high", BASE + 32'h4, 32'h10);
        bus_write(BASE + 32'h4, 32'h10, 2'd1);
        bus_read("lvl_pend_w1c_ignored", BASE + 32'h4, 32'h10);
        ack();
        wait_int(n);
        chk("lvl_holdoff_low_cycles", n, HOLDOFF + 1);
        sb_check("lvl_intnum_second", INTnum);
        irq = 8'h00;
        tick();
        bus_read("lvl_pend_low", BASE + 32'h4, 32'h00);
        ack();
        drain();
        chk("lvl_drained_intout", {31'h0, INTout}, 32'h0);
        bus_read("lvl_mask", BASE, 32'h10);
`endif

        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
